// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore-style control unit that steps a single-bus datapath through
//   fetch (T0..T2) and execute (T3..T7) for each instruction.
//   Every output depends only on the current step and IR[31:27].
//   While clr is high, every output, including run, is forced low.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-high reset
//   IR[31:0]   in   instruction register, opcode in IR[31:27]
//   mem_done   in   memory handshake completion, sampled on rising clk
//   PCout .. Cout                   out  datapath control strobes
//   Gra, Grb, Grc, Rin, Rout, BAout out  register-field select/encode controls
//   ALU_opcode[4:0]                 out  ALU operation select
//   mem_read, mem_write             out  memory requests
//   run        out  high while sequencing, low in HALT and during clr
//   state[3:0] out  current step, T0..T7 = 0..7, HALT = 4'hF
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_done,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        MDRin,
  output logic        MDRread,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        Loin,
  output logic        HIout,
  output logic        Loout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  ALU_opcode,
  output logic        mem_read,
  output logic        mem_write,
  output logic        run,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_T0   = 4'h0,
    S_T1   = 4'h1,
    S_T2   = 4'h2,
    S_T3   = 4'h3,
    S_T4   = 4'h4,
    S_T5   = 4'h5,
    S_T6   = 4'h6,
    S_T7   = 4'h7,
    S_HALT = 4'hF
  } step_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;

  step_t      cur_step;
  step_t      nxt_step;
  logic [4:0] opc;

  // Only the opcode field steers sequencing; the operand fields are
  // consumed by the register-select logic elsewhere in the datapath.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  assign opc = IR[31:27];

  logic is_alu;
  logic is_addi;
  logic is_ld;
  logic is_st;
  logic is_muldiv;
  logic is_mfhi;
  logic is_mflo;
  logic is_halt;

  assign is_alu    = (opc == OP_ADD) || (opc == OP_SUB) ||
                     (opc == OP_AND) || (opc == OP_OR);
  assign is_addi   = (opc == OP_ADDI);
  assign is_ld     = (opc == OP_LD);
  assign is_st     = (opc == OP_ST);
  assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
  assign is_mfhi   = (opc == OP_MFHI);
  assign is_mflo   = (opc == OP_MFLO);
  assign is_halt   = (opc == OP_HALT);

  // Step register: clr overrides any pending transition, including a
  // wait step that would otherwise complete on the same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cur_step <= S_T0;
    end else begin
      cur_step <= nxt_step;
    end
  end

  assign state = cur_step;

  // Next step and control strobes. Outputs are gated by clr so that an
  // asynchronous reset silences the datapath without waiting for clk.
  always_comb begin
    nxt_step   = cur_step;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    MDRin      = 1'b0;
    MDRread    = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    HIin       = 1'b0;
    Loin       = 1'b0;
    HIout      = 1'b0;
    Loout      = 1'b0;
    Cout       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    ALU_opcode = 5'b00000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    run        = 1'b0;

    case (cur_step)
      S_T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        nxt_step = S_T1;
      end
      S_T1: begin
        mem_read = 1'b1;
        MDRread  = 1'b1;
        MDRin    = 1'b1;
        nxt_step = mem_done ? S_T2 : S_T1;
      end
      S_T2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        nxt_step = S_T3;
      end
      S_T3: begin
        nxt_step = S_T4;
        if (is_alu || is_addi) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_ld || is_st) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (is_muldiv) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_mfhi) begin
          HIout    = 1'b1;
          Gra      = 1'b1;
          Rin      = 1'b1;
          nxt_step = S_T0;
        end else if (is_mflo) begin
          Loout    = 1'b1;
          Gra      = 1'b1;
          Rin      = 1'b1;
          nxt_step = S_T0;
        end else if (is_halt) begin
          nxt_step = S_HALT;
        end else begin
          nxt_step = S_T0;
        end
      end
      S_T4: begin
        nxt_step = S_T5;
        if (is_alu) begin
          Grc        = 1'b1;
          Rout       = 1'b1;
          Zin        = 1'b1;
          ALU_opcode = opc;
        end else if (is_addi || is_ld || is_st) begin
          Cout       = 1'b1;
          Zin        = 1'b1;
          ALU_opcode = ALU_ADD;
        end else if (is_muldiv) begin
          Grb        = 1'b1;
          Rout       = 1'b1;
          Zin        = 1'b1;
          ALU_opcode = opc;
        end else begin
          nxt_step = S_T0;
        end
      end
      S_T5: begin
        nxt_step = S_T0;
        if (is_alu || is_addi) begin
          ZLOout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_ld || is_st) begin
          ZLOout   = 1'b1;
          MARin    = 1'b1;
          nxt_step = S_T6;
        end else if (is_muldiv) begin
          ZLOout   = 1'b1;
          Loin     = 1'b1;
          nxt_step = S_T6;
        end
      end
      S_T6: begin
        nxt_step = S_T0;
        if (is_ld) begin
          mem_read = 1'b1;
          MDRread  = 1'b1;
          MDRin    = 1'b1;
          nxt_step = mem_done ? S_T7 : S_T6;
        end else if (is_st) begin
          // Register operand goes onto the bus into MDR, not from memory.
          Gra      = 1'b1;
          Rout     = 1'b1;
          MDRin    = 1'b1;
          nxt_step = S_T7;
        end else if (is_muldiv) begin
          ZHIout = 1'b1;
          HIin   = 1'b1;
        end
      end
      S_T7: begin
        nxt_step = S_T0;
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_st) begin
          mem_write = 1'b1;
          nxt_step  = mem_done ? S_T0 : S_T7;
        end
      end
      S_HALT: begin
        nxt_step = S_HALT;
      end
      default: begin
        nxt_step = S_T0;
      end
    endcase

    run = (cur_step != S_HALT);

    if (clr) begin
      PCout      = 1'b0;
      MARin      = 1'b0;
      IncPC      = 1'b0;
      MDRin      = 1'b0;
      MDRread    = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      Zin        = 1'b0;
      ZLOout     = 1'b0;
      ZHIout     = 1'b0;
      HIin       = 1'b0;
      Loin       = 1'b0;
      HIout      = 1'b0;
      Loout      = 1'b0;
      Cout       = 1'b0;
      Gra        = 1'b0;
      Grb        = 1'b0;
      Grc        = 1'b0;
      Rin        = 1'b0;
      Rout       = 1'b0;
      BAout      = 1'b0;
      ALU_opcode = 5'b00000;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      run        = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        mem_done;
  logic PCout, MARin, IncPC, MDRin, MDRread, MDRout, IRin, Yin, Zin;
  logic ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] ALU_opcode;
  logic mem_read, mem_write, run;
  logic [3:0] state;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_done(mem_done),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .MDRin(MDRin),
    .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .Loin(Loin),
    .HIout(HIout), .Loout(Loout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ALU_opcode(ALU_opcode), .mem_read(mem_read), .mem_write(mem_write),
    .run(run), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe masks, MSB = PCout down to LSB = mem_write.
  localparam logic [23:0] M_PC    = 24'h800000;
  localparam logic [23:0] M_MARIN = 24'h400000;
  localparam logic [23:0] M_INC   = 24'h200000;
  localparam logic [23:0] M_MDRIN = 24'h100000;
  localparam logic [23:0] M_MDRRD = 24'h080000;
  localparam logic [23:0] M_MDROU = 24'h040000;
  localparam logic [23:0] M_IRIN  = 24'h020000;
  localparam logic [23:0] M_YIN   = 24'h010000;
  localparam logic [23:0] M_ZIN   = 24'h008000;
  localparam logic [23:0] M_ZLO   = 24'h004000;
  localparam logic [23:0] M_ZHI   = 24'h002000;
  localparam logic [23:0] M_HIIN  = 24'h001000;
  localparam logic [23:0] M_LOIN  = 24'h000800;
  localparam logic [23:0] M_HIOU  = 24'h000400;
  localparam logic [23:0] M_LOOU  = 24'h000200;
  localparam logic [23:0] M_COUT  = 24'h000100;
  localparam logic [23:0] M_GRA   = 24'h000080;
  localparam logic [23:0] M_GRB   = 24'h000040;
  localparam logic [23:0] M_GRC   = 24'h000020;
  localparam logic [23:0] M_RIN   = 24'h000010;
  localparam logic [23:0] M_ROUT  = 24'h000008;
  localparam logic [23:0] M_BA    = 24'h000004;
  localparam logic [23:0] M_MRD   = 24'h000002;
  localparam logic [23:0] M_MWR   = 24'h000001;

  localparam logic [23:0] X_T0 = M_PC | M_MARIN | M_INC;
  localparam logic [23:0] X_T1 = M_MRD | M_MDRRD | M_MDRIN;
  localparam logic [23:0] X_T2 = M_MDROU | M_IRIN;

  logic [23:0] strobes;
  assign strobes = {PCout, MARin, IncPC, MDRin, MDRread, MDRout, IRin, Yin,
                    Zin, ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout,
                    Gra, Grb, Grc, Rin, Rout, BAout, mem_read, mem_write};

  typedef struct {
    logic [31:0] ir;
    logic        md;
    logic [3:0]  st;
    logic [23:0] stb;
    logic [4:0]  alu;
    logic        rn;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic [31:0] ir, input logic md, input logic [3:0] st,
                   input logic [23:0] stb, input logic [4:0] alu,
                   input logic rn);
    vec_t e;
    e.ir = ir; e.md = md; e.st = st; e.stb = stb; e.alu = alu; e.rn = rn;
    vecs.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ir);
    v(ir, 1'b1, 4'h0, X_T0, 5'd0, 1'b1);
    v(ir, 1'b1, 4'h1, X_T1, 5'd0, 1'b1);
    v(ir, 1'b1, 4'h2, X_T2, 5'd0, 1'b1);
  endtask

  task automatic alu3(input logic [31:0] ir);
    fetch(ir);
    v(ir, 1'b1, 4'h3, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    v(ir, 1'b1, 4'h4, M_GRC | M_ROUT | M_ZIN, ir[31:27], 1'b1);
    v(ir, 1'b1, 4'h5, M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1);
  endtask

  task automatic muldiv(input logic [31:0] ir);
    fetch(ir);
    v(ir, 1'b1, 4'h3, M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1);
    v(ir, 1'b1, 4'h4, M_GRB | M_ROUT | M_ZIN, ir[31:27], 1'b1);
    v(ir, 1'b1, 4'h5, M_ZLO | M_LOIN, 5'd0, 1'b1);
    v(ir, 1'b0, 4'h6, M_ZHI | M_HIIN, 5'd0, 1'b1);
  endtask

  task automatic ldst_head(input logic [31:0] ir);
    fetch(ir);
    v(ir, 1'b1, 4'h3, M_GRB | M_BA | M_YIN, 5'd0, 1'b1);
    v(ir, 1'b1, 4'h4, M_COUT | M_ZIN, 5'b00011, 1'b1);
    v(ir, 1'b1, 4'h5, M_ZLO | M_MARIN, 5'd0, 1'b1);
  endtask

  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_LD   = 32'h00800000;
  localparam logic [31:0] I_ST   = 32'h10800000;
  localparam logic [31:0] I_MUL  = 32'h78000000;
  localparam logic [31:0] I_DIV  = 32'h80000000;
  localparam logic [31:0] I_SUB  = 32'h20000000;
  localparam logic [31:0] I_ADDI = 32'h60000000;
  localparam logic [31:0] I_MFHI = 32'hC0000000;
  localparam logic [31:0] I_MFLO = 32'hC8000000;
  localparam logic [31:0] I_NOP  = 32'hA8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  initial begin
    // add with a three-cycle memory wait in fetch
    v(I_ADD, 1'b1, 4'h0, X_T0, 5'd0, 1'b1);
    v(I_ADD, 1'b0, 4'h1, X_T1, 5'd0, 1'b1);
    v(I_ADD, 1'b0, 4'h1, X_T1, 5'd0, 1'b1);
    v(I_ADD, 1'b0, 4'h1, X_T1, 5'd0, 1'b1);
    v(I_ADD, 1'b1, 4'h1, X_T1, 5'd0, 1'b1);
    v(I_ADD, 1'b1, 4'h2, X_T2, 5'd0, 1'b1);
    v(I_ADD, 1'b1, 4'h3, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    v(I_ADD, 1'b1, 4'h4, M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1);
    v(I_ADD, 1'b1, 4'h5, M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1);
    // ld with two wait cycles at T6
    ldst_head(I_LD);
    v(I_LD, 1'b0, 4'h6, X_T1, 5'd0, 1'b1);
    v(I_LD, 1'b0, 4'h6, X_T1, 5'd0, 1'b1);
    v(I_LD, 1'b1, 4'h6, X_T1, 5'd0, 1'b1);
    v(I_LD, 1'b0, 4'h7, M_MDROU | M_GRA | M_RIN, 5'd0, 1'b1);
    // st: mem_done low at T6 is ignored, one wait at T7
    ldst_head(I_ST);
    v(I_ST, 1'b0, 4'h6, M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
    v(I_ST, 1'b0, 4'h7, M_MWR, 5'd0, 1'b1);
    v(I_ST, 1'b1, 4'h7, M_MWR, 5'd0, 1'b1);
    muldiv(I_MUL);
    muldiv(I_DIV);
    alu3(I_SUB);
    fetch(I_ADDI);
    v(I_ADDI, 1'b1, 4'h3, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    v(I_ADDI, 1'b1, 4'h4, M_COUT | M_ZIN, 5'b00011, 1'b1);
    v(I_ADDI, 1'b1, 4'h5, M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1);
    fetch(I_MFHI);
    v(I_MFHI, 1'b1, 4'h3, M_HIOU | M_GRA | M_RIN, 5'd0, 1'b1);
    fetch(I_MFLO);
    v(I_MFLO, 1'b1, 4'h3, M_LOOU | M_GRA | M_RIN, 5'd0, 1'b1);
    fetch(I_NOP);
    v(I_NOP, 1'b1, 4'h3, 24'h0, 5'd0, 1'b1);
    fetch(I_HALT);
    v(I_HALT, 1'b1, 4'h3, 24'h0, 5'd0, 1'b1);
    v(I_HALT, 1'b1, 4'hF, 24'h0, 5'd0, 1'b0);
    v(I_HALT, 1'b0, 4'hF, 24'h0, 5'd0, 1'b0);
    v(I_HALT, 1'b1, 4'hF, 24'h0, 5'd0, 1'b0);

    clr = 1'b1;
    IR = I_ADD;
    mem_done = 1'b1;
    #2;
    check("reset_state", {28'd0, state}, 32'h0);
    check("reset_strobes", {8'd0, strobes}, 32'h0);
    check("reset_run", {31'd0, run}, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      IR = vecs[i].ir;
      mem_done = vecs[i].md;
      #1;
      check($sformatf("v%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      check($sformatf("v%0d_strobes", i), {8'd0, strobes}, {8'd0, vecs[i].stb});
      check($sformatf("v%0d_alu", i), {27'd0, ALU_opcode}, {27'd0, vecs[i].alu});
      check($sformatf("v%0d_run", i), {31'd0, run}, {31'd0, vecs[i].rn});
      @(negedge clk);
    end

    // clr pulse leaves HALT
    clr = 1'b1;
    #1;
    check("halt_clr_state", {28'd0, state}, 32'h0);
    check("halt_clr_run", {31'd0, run}, 32'h0);
    #1 clr = 1'b0;
    #1;
    check("halt_rel_run", {31'd0, run}, 32'h1);
    check("halt_rel_strobes", {8'd0, strobes}, {8'd0, X_T0});
    @(negedge clk);
    #1;
    check("halt_rel_next", {28'd0, state}, 32'h1);

    // async clr in the middle of sub T4
    clr = 1'b1;
    IR = I_SUB;
    mem_done = 1'b1;
    #1 clr = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("sub_t4_state", {28'd0, state}, 32'h4);
    check("sub_t4_zin", {31'd0, Zin}, 32'h1);
    check("sub_t4_alu", {27'd0, ALU_opcode}, 32'h4);
    clr = 1'b1;
    #1;
    check("async_clr_strobes", {8'd0, strobes}, 32'h0);
    check("async_clr_alu", {27'd0, ALU_opcode}, 32'h0);
    check("async_clr_run", {31'd0, run}, 32'h0);
    check("async_clr_state", {28'd0, state}, 32'h0);
    // clr and mem_done on the same edge: no transition
    @(posedge clk);
    #1;
    check("clr_wins_state", {28'd0, state}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("post_clr_pcout", {31'd0, PCout}, 32'h1);
    check("post_clr_run", {31'd0, run}, 32'h1);
    @(posedge clk);
    #1;
    check("post_clr_t1", {28'd0, state}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter ALU_ADD, default 5'b00011, is the ALU_opcode driven for effective-address and immediate additions.
REQ-002 Parameter OP_HALT, default 5'b11011, is the IR opcode that stops sequencing.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 IR  input  32  instruction register contents: opcode IR[31:27].
REQ-006 mem_done  input  1  memory handshake completion, sampled on rising clk.
REQ-007 PCout, MARin, IncPC, MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout  output  1 each  datapath control strobes.
REQ-008 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select-and-encode controls for the IR register fields.
REQ-009 ALU_opcode  output  5  ALU operation select.
REQ-010 mem_read, mem_write  output  1 each  memory requests.
REQ-011 run  output  1  high while sequencing; low in HALT.
REQ-012 state  output  4  current step: T0..T7 = 0..7, HALT = 4'hF.

Function
REQ-013 Moore FSM: every output is a function of state and IR[31:27] only; unlisted outputs are 0 in each step.
REQ-014 T0: PCout, MARin, IncPC; next T1.
REQ-015 T1: mem_read, MDRread, MDRin; hold T1 until mem_done sampled 1, then T2.
REQ-016 T2: MDRout, IRin; next T3. IR is decoded from T3 on, stable until the next T2.
REQ-017 add/sub/and/or (00011/00100/00101/00110): T3 Grb Rout Yin; T4 Grc Rout Zin, ALU_opcode=IR[31:27]; T5 ZLOout Gra Rin; then T0.
REQ-018 addi (01100): T3 Grb Rout Yin; T4 Cout Zin, ALU_opcode=ALU_ADD; T5 ZLOout Gra Rin; then T0.
REQ-019 ld (00000): T3 Grb BAout Yin; T4 Cout Zin, ALU_ADD; T5 ZLOout MARin; T6 mem_read MDRread MDRin, hold until mem_done; T7 MDRout Gra Rin; then T0.
REQ-020 st (00010): T3-T5 as ld; T6 Gra Rout MDRin (MDRread=0); T7 mem_write, hold until mem_done; then T0.
REQ-021 mul/div (01111/10000): T3 Gra Rout Yin; T4 Grb Rout Zin, ALU_opcode=IR[31:27]; T5 ZLOout Loin; T6 ZHIout HIin; then T0.
REQ-022 mfhi (11000): T3 HIout Gra Rin; mflo (11001): T3 Loout Gra Rin; then T0.
REQ-023 OP_HALT at T3: next state HALT; HALT holds all strobes 0, run=0, until clr.
REQ-024 Any other opcode: T3 asserts nothing, next T0 (nop).
REQ-025 mem_done sampled outside T1/T6(ld)/T7(st) is ignored; mem_done held high completes a wait step in one cycle.
REQ-026 ALU_opcode is 0 in every step not listed above.
REQ-027 Minimum instruction latencies: ALU/addi 6 cycles, mul/div 7, ld/st 8, mfhi/mflo 4, each plus memory wait cycles.

Reset
REQ-028 clr high asynchronously forces state to T0 and all outputs, including run, to 0, regardless of step or pending wait.
REQ-029 After clr falls, T0 outputs assert (run=1, PCout=1) and the first rising edge advances to T1.
REQ-030 clr and mem_done asserted on the same edge: clr wins, no transition.

Verification
REQ-031 IR=0x18918000 (add R1,R2,R3), mem_done=1 throughout -> states 0,1,2,3,4,5,0; T4 Zin=1, Grc=1, ALU_opcode=00011; T5 ZLOout=Gra=Rin=1.
REQ-032 mem_done=0 for 3 cycles in T1 -> state stays 1 for 4 cycles with mem_read=MDRread=MDRin=1, then 2.
REQ-033 ld, IR[31:27]=00000, mem_done low 2 cycles at T6 -> T6 held 3 cycles; T7 MDRout=Gra=Rin=1; T4 ALU_opcode=00011, BAout=1 only in T3.
REQ-034 mul (01111) -> T5 ZLOout=Loin=1, T6 ZHIout=HIin=1, then state 0.
REQ-035 IR[31:27]=11011 -> state 4'hF, run=0, all strobes 0 while mem_done toggles; clr pulse -> state 0, run=1.
REQ-036 clr pulsed asynchronously mid-T4 of sub -> outputs 0 immediately without waiting for clk; after release state 0, PCout=1.
